// File: rtl/i2s_sample_serializer.sv
// Purpose: pops 20-bit mono samples from the sample FIFO and shifts each one out on both slots of a Philips I2S frame.
// Latency: FIFO non-empty at T -> fifo_rd_en at T+1, capture at T+2, first frame (lrck low, bit 0) from T+3.
// Backpressure: one pop per frame into a single prefetch register; an empty FIFO at a frame boundary yields a zero frame plus an underrun pulse.
module i2s_sample_serializer #(
    parameter int SAMPLE_WIDTH = 20,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_HALF    = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic                    i2s_bclk,
    output logic                    i2s_lrck,
    output logic                    i2s_sdata,
    output logic                    underrun
);

    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] SLOT_L   = BIT_W'(SLOT_WIDTH);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BCLK_HALF - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } main_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_RD,
        F_CAP
    } fetch_state_t;

    main_state_t               main_state_q;
    fetch_state_t              fetch_state_q;

    logic [DIV_W-1:0]          div_cnt_q;
    logic [DIV_W-1:0]          div_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q;
    logic [BIT_W-1:0]          bit_cnt_d;
    logic [BIT_W-1:0]          slot_pos_d;
    logic                      bclk_q;
    logic                      lrck_q;
    logic                      lrck_d;
    logic                      sdata_q;
    logic                      sdata_d;
    logic                      underrun_q;
    logic                      rd_en_q;
    logic [SAMPLE_WIDTH-1:0]   cur_sample_q;
    logic [SAMPLE_WIDTH-1:0]   next_sample_q;
    logic                      next_valid_q;

    logic                      div_wrap;
    logic                      bclk_fall;
    logic                      bit_wrap;
    logic                      frame_start;

    // Bit-clock divider, bit counter advance and the serial bit for the next bclk period.
    always_comb begin
        div_wrap    = (div_cnt_q == LAST_DIV);
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + 1'b1;
        bclk_fall   = (main_state_q == S_RUN) && div_wrap && bclk_q;
        bit_wrap    = bclk_fall && (bit_cnt_q == LAST_BIT);
        bit_cnt_d   = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
        lrck_d      = (bit_cnt_d >= SLOT_L);
        slot_pos_d  = lrck_d ? (bit_cnt_d - SLOT_L) : bit_cnt_d;
        // Entering RUN and every 64-bit wrap both consume the prefetched sample.
        frame_start = ((main_state_q == S_IDLE) && next_valid_q) || bit_wrap;
        // Position 0 is the one-bclk I2S delay slot; MSB lands at position 1.
        sdata_d     = 1'b0;
        for (int k = 1; k <= SAMPLE_WIDTH; k++) begin
            if (slot_pos_d == BIT_W'(k)) begin
                sdata_d = cur_sample_q[SAMPLE_WIDTH-k];
            end
        end
    end

    // Main FSM: idles until a sample is prefetched, then clocks frames out forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_state_q <= S_IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            bclk_q       <= 1'b0;
            lrck_q       <= 1'b0;
            sdata_q      <= 1'b0;
            underrun_q   <= 1'b0;
            cur_sample_q <= '0;
        end else begin
            underrun_q <= 1'b0;
            case (main_state_q)
                S_IDLE: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    bclk_q    <= 1'b0;
                    lrck_q    <= 1'b0;
                    sdata_q   <= 1'b0;
                    if (next_valid_q) begin
                        main_state_q <= S_RUN;
                        cur_sample_q <= next_sample_q;
                    end
                end
                S_RUN: begin
                    div_cnt_q <= div_cnt_d;
                    if (div_wrap) begin
                        bclk_q <= ~bclk_q;
                    end
                    // Data and word select move only on the falling bclk edge.
                    if (bclk_fall) begin
                        bit_cnt_q <= bit_cnt_d;
                        lrck_q    <= lrck_d;
                        sdata_q   <= sdata_d;
                    end
                    // The boundary sees next_valid before any same-cycle capture.
                    if (bit_wrap) begin
                        if (next_valid_q) begin
                            cur_sample_q <= next_sample_q;
                        end else begin
                            cur_sample_q <= '0;
                            underrun_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    main_state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Fetch FSM: one-cycle pop, capture the non-FWFT read data a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_state_q <= F_IDLE;
            rd_en_q       <= 1'b0;
            next_sample_q <= '0;
            next_valid_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            if (frame_start && next_valid_q) begin
                next_valid_q <= 1'b0;
            end
            case (fetch_state_q)
                F_IDLE: begin
                    // Retries every cycle while the FIFO is empty and the slot is free.
                    if (!next_valid_q && !fifo_empty) begin
                        fetch_state_q <= F_RD;
                        rd_en_q       <= 1'b1;
                    end
                end
                F_RD: begin
                    fetch_state_q <= F_CAP;
                end
                F_CAP: begin
                    next_sample_q <= fifo_dout;
                    next_valid_q  <= 1'b1;
                    fetch_state_q <= F_IDLE;
                end
                default: begin
                    fetch_state_q <= F_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrck   = lrck_q;
    assign i2s_sdata  = sdata_q;
    assign underrun   = underrun_q;

endmodule
